// File: rtl/ctrlreg_pkg.sv
// rtl/ctrlreg_pkg.sv - shared opcodes, FSM encodings and default width for the control-register arbiter
package ctrlreg_pkg;

   localparam int CTRL_WIDTH = 16;

   localparam logic [1:0] CTRL_OP_WRITE  = 2'b00;
   localparam logic [1:0] CTRL_OP_SET    = 2'b01;
   localparam logic [1:0] CTRL_OP_CLEAR  = 2'b10;
   localparam logic [1:0] CTRL_OP_TOGGLE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_APPLY  = 2'b01,
      ST_ACK    = 2'b10
`ifdef CTRLREG_ARB_LOCK_EN
      , ST_LOCKED = 2'b11
`endif
   } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin selector searching upward from last+1 with wrap
module rr_priority_picker #(
   parameter int  N   = 4,
   localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   output logic [N-1:0]   grant,
   output logic [IDW-1:0] idx,
   output logic           valid
);

   // first set request bit after last, wrapping; offset N revisits last itself
   always_comb begin
      int cand;
      cand  = 0;
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      for (int i = 1; i <= N; i++) begin
         cand = (int'(last) + i) % N;
         if (!valid && req[cand]) begin
            valid       = 1'b1;
            grant[cand] = 1'b1;
            idx         = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/control_register_arbiter.sv
// rtl/control_register_arbiter.sv - round-robin read-modify-write arbiter for the control register (lock mode under CTRLREG_ARB_LOCK_EN)
module control_register_arbiter
   import ctrlreg_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   parameter int  WIDTH   = CTRL_WIDTH,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [NUM_REQ-1:0]       iReq,
   input  logic [2*NUM_REQ-1:0]     iOp,
   input  logic [WIDTH*NUM_REQ-1:0] iData,
   input  logic [NUM_REQ-1:0]       iLock,
   input  logic [WIDTH-1:0]         iControlRegisterQ,
   output logic [WIDTH-1:0]         oControlRegisterD,
   output logic [NUM_REQ-1:0]       oAck,
   output logic [IDW-1:0]           oGrantId,
   output logic                     oBusy
);

   arb_state_e         state, state_next;
   logic [IDW-1:0]     last;
   logic [IDW-1:0]     grant_id;
   logic [IDW-1:0]     pick_idx;
   logic [IDW-1:0]     sel_id;
   logic [NUM_REQ-1:0] pick_onehot_unused;
   logic               pick_valid;
   logic               take;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   data_q;

`ifndef CTRLREG_ARB_LOCK_EN
   logic unused_lock;
   assign unused_lock = ^iLock;
`endif

   function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] q,
                                                 input logic [WIDTH-1:0] d);
      case (op)
         CTRL_OP_WRITE: apply_op = d;
         CTRL_OP_SET:   apply_op = q | d;
         CTRL_OP_CLEAR: apply_op = q & ~d;
         default:       apply_op = q ^ d;
      endcase
   endfunction

   rr_priority_picker #(.N(NUM_REQ)) u_picker (
      .req   (iReq),
      .last  (last),
      .grant (pick_onehot_unused),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // a grant is taken whenever the FSM is about to apply; in LOCKED the owner is re-granted
   assign take   = (state_next == ST_APPLY);
   assign sel_id = (state == ST_IDLE) ? pick_idx : grant_id;

   // state register; reset aborts any operation in flight
   always_ff @(posedge Clock) begin
      if (Reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   // next-state logic
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (pick_valid) state_next = ST_APPLY;
         ST_APPLY: state_next = ST_ACK;
`ifdef CTRLREG_ARB_LOCK_EN
         ST_ACK:   state_next = iLock[grant_id] ? ST_LOCKED : ST_IDLE;
         ST_LOCKED: begin
            if (!iLock[grant_id])     state_next = ST_IDLE;
            else if (iReq[grant_id])  state_next = ST_APPLY;
         end
`else
         ST_ACK:   state_next = ST_IDLE;
`endif
         default:  state_next = ST_IDLE;
      endcase
   end

   // capture winner and operands at grant so later iOp/iData changes cannot disturb the operation
   always_ff @(posedge Clock) begin
      if (Reset) begin
         last     <= IDW'(NUM_REQ - 1);
         grant_id <= '0;
         op_q     <= CTRL_OP_WRITE;
         data_q   <= '0;
      end else begin
         if (take) begin
            grant_id <= sel_id;
            op_q     <= iOp[2*sel_id +: 2];
            data_q   <= iData[WIDTH*sel_id +: WIDTH];
         end
         if (state == ST_ACK) last <= grant_id;
      end
   end

   // outputs: register held except in APPLY, one-hot ack in ACK
   always_comb begin
      oControlRegisterD = iControlRegisterQ;
      oAck              = '0;
      oBusy             = (state != ST_IDLE);
      oGrantId          = grant_id;
      if (state == ST_APPLY) oControlRegisterD = apply_op(op_q, iControlRegisterQ, data_q);
      if (state == ST_ACK)   oAck[grant_id] = 1'b1;
   end

endmodule

// File: tb/tb_control_register_arbiter.sv
// tb/tb_control_register_arbiter.sv - scoreboard bench for control_register_arbiter
module tb_control_register_arbiter;
   import ctrlreg_pkg::*;

   localparam int NUM_REQ = 4;
   localparam int WIDTH   = 16;

   logic                     Clock;
   logic                     Reset;
   logic [NUM_REQ-1:0]       iReq;
   logic [2*NUM_REQ-1:0]     iOp;
   logic [WIDTH*NUM_REQ-1:0] iData;
   logic [NUM_REQ-1:0]       iLock;
   logic [WIDTH-1:0]         ctrl_q;
   logic [WIDTH-1:0]         oControlRegisterD;
   logic [NUM_REQ-1:0]       oAck;
   logic [1:0]               oGrantId;
   logic                     oBusy;

   control_register_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .Clock             (Clock),
      .Reset             (Reset),
      .iReq              (iReq),
      .iOp               (iOp),
      .iData             (iData),
      .iLock             (iLock),
      .iControlRegisterQ (ctrl_q),
      .oControlRegisterD (oControlRegisterD),
      .oAck              (oAck),
      .oGrantId          (oGrantId),
      .oBusy             (oBusy)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // the control register itself
   always_ff @(posedge Clock) begin
      if (Reset) ctrl_q <= '0;
      else       ctrl_q <= oControlRegisterD;
   end

   typedef struct {
      int               id;
      logic [WIDTH-1:0] val;
   } exp_t;

   exp_t             sb[$];
   exp_t             mon_e;
   logic [WIDTH-1:0] model_q;
   int               checks = 0;
   int               errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op,
                                               input logic [WIDTH-1:0] q,
                                               input logic [WIDTH-1:0] d);
      if (op == 2'b00)      return d;
      else if (op == 2'b01) return q | d;
      else if (op == 2'b10) return q & ~d;
      else                  return q ^ d;
   endfunction

   task automatic expect_op(input int id, input logic [1:0] op, input logic [WIDTH-1:0] d);
      exp_t e;
      model_q = ref_op(op, model_q, d);
      e.id  = id;
      e.val = model_q;
      sb.push_back(e);
   endtask

   task automatic drive(input int id, input logic [1:0] op, input logic [WIDTH-1:0] d);
      iReq[id]              = 1'b1;
      iOp[2*id +: 2]        = op;
      iData[WIDTH*id +: WIDTH] = d;
   endtask

   task automatic wait_ack(output int n, output int busy_n);
      n      = 0;
      busy_n = 0;
      do begin
         @(negedge Clock);
         n++;
         if (oBusy) busy_n++;
      end while (oAck == '0 && n < 20);
      check("ack_timeout", {31'b0, |oAck}, 32'd1);
   endtask

   task automatic do_op(input int id, input logic [1:0] op, input logic [WIDTH-1:0] d);
      int n, b;
      expect_op(id, op, d);
      drive(id, op, d);
      wait_ack(n, b);
      check("latency", n, 2);
      check("busy_cycles", b, 2);
      iReq[id] = 1'b0;
      @(negedge Clock);
      check("idle_busy", {31'b0, oBusy}, 0);
   endtask

   // scoreboard: every ack pops the next expected winner and register value
   always @(negedge Clock) begin
      if (!Reset && oAck != '0) begin
         if (sb.size() == 0) begin
            check("ack_unexpected", {28'b0, oAck}, 0);
         end else begin
            mon_e = sb.pop_front();
            check("ack_id", {30'b0, oGrantId}, mon_e.id);
            check("ack_onehot", {28'b0, oAck}, 1 << mon_e.id);
            check("reg_value", {16'b0, ctrl_q}, {16'b0, mon_e.val});
         end
      end
   end

   initial begin
      int n, b;
      Reset   = 1'b1;
      iReq    = '0;
      iOp     = '0;
      iData   = '0;
      iLock   = '0;
      model_q = '0;
      repeat (3) @(negedge Clock);
      check("rst_ack", {28'b0, oAck}, 0);
      check("rst_busy", {31'b0, oBusy}, 0);
      check("rst_grant", {30'b0, oGrantId}, 0);
      check("rst_d", {16'b0, oControlRegisterD}, 0);
      Reset = 1'b0;

      do_op(1, CTRL_OP_WRITE, 16'hA5A5);
      check("t1_reg", {16'b0, ctrl_q}, 32'h0000A5A5);

      do_op(0, CTRL_OP_WRITE, 16'h00F0);
      do_op(0, CTRL_OP_SET, 16'h0F00);
      check("t2_set", {16'b0, ctrl_q}, 32'h00000FF0);
      do_op(2, CTRL_OP_CLEAR, 16'h00F0);
      check("t2_clear", {16'b0, ctrl_q}, 32'h00000F00);
      do_op(3, CTRL_OP_TOGGLE, 16'hFFFF);
      check("t2_toggle", {16'b0, ctrl_q}, 32'h0000F0FF);

      for (int a = 0; a < 5; a++) expect_op(a % 4, CTRL_OP_TOGGLE, 16'(32'h1 << (4 * (a % 4))));
      for (int k = 0; k < 4; k++) drive(k, CTRL_OP_TOGGLE, 16'(32'h1 << (4 * k)));
      wait_ack(n, b);
      check("rr_first_latency", n, 2);
      for (int a = 1; a < 5; a++) begin
         wait_ack(n, b);
         check("rr_spacing", n, 3);
      end
      iReq = '0;
      @(negedge Clock);
      check("rr_reg", {16'b0, ctrl_q}, 32'h0000E1EF);

      expect_op(2, CTRL_OP_WRITE, 16'h0001);
      drive(2, CTRL_OP_WRITE, 16'h0001);
      @(negedge Clock);
      check("apply_busy", {31'b0, oBusy}, 1);
      iData[WIDTH*2 +: WIDTH] = 16'hFFFF;
      iOp[5:4]                = CTRL_OP_TOGGLE;
      wait_ack(n, b);
      check("latched_latency", n, 1);
      iReq[2] = 1'b0;
      @(negedge Clock);
      check("latched_reg", {16'b0, ctrl_q}, 32'h00000001);

      do_op(0, CTRL_OP_SET, 16'h0100);
      drive(1, CTRL_OP_WRITE, 16'h1234);
      @(negedge Clock);
      check("abort_d", {16'b0, oControlRegisterD}, 32'h00001234);
      Reset = 1'b1;
      iReq  = '0;
      @(negedge Clock);
      check("abort_ack", {28'b0, oAck}, 0);
      check("abort_busy", {31'b0, oBusy}, 0);
      check("abort_reg", {16'b0, ctrl_q}, 0);
      check("abort_grant", {30'b0, oGrantId}, 0);
      model_q = '0;
      Reset   = 1'b0;
      expect_op(0, CTRL_OP_SET, 16'h0003);
      expect_op(1, CTRL_OP_SET, 16'h0300);
      drive(0, CTRL_OP_SET, 16'h0003);
      drive(1, CTRL_OP_SET, 16'h0300);
      wait_ack(n, b);
      iReq[0] = 1'b0;
      wait_ack(n, b);
      check("post_reset_second", n, 3);
      iReq[1] = 1'b0;
      @(negedge Clock);

`ifdef CTRLREG_ARB_LOCK_EN
      for (int a = 0; a < 4; a++) expect_op(1, CTRL_OP_TOGGLE, 16'h0010);
      expect_op(0, CTRL_OP_SET, 16'h8000);
      iLock[1] = 1'b1;
      drive(1, CTRL_OP_TOGGLE, 16'h0010);
      wait_ack(n, b);
      drive(0, CTRL_OP_SET, 16'h8000);
      for (int a = 1; a < 4; a++) begin
         wait_ack(n, b);
         check("lock_spacing", n, 3);
      end
      iLock[1] = 1'b0;
      iReq[1]  = 1'b0;
      wait_ack(n, b);
      check("unlock_latency", n, 3);
      iReq[0] = 1'b0;
      @(negedge Clock);
`endif

      repeat (3) @(negedge Clock);
      check("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_register_arbiter.md
# control_register_arbiter

Sequences and shares write access to the 16-bit `ControlRegister` among `NUM_REQ` requesters, such as the host interface, the control unit and the execution units. Each requester issues a read-modify-write operation (write, set, clear or toggle). A round-robin FSM grants one request at a time, drives the register's `iControlRegister` input for exactly one cycle, and acknowledges the winner. Between operations the block feeds the register's own output back to its input, so the register holds its value.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 16: control-register width.

Ports:
- `Clock`  in  1  clock.
- `Reset`  in  1  synchronous, active-high reset.
- `iReq`  in  `NUM_REQ`  per-requester request level.
- `iOp`  in  `2*NUM_REQ`  per-requester opcode, requester k at bits [2k+1:2k]: 00 write, 01 set, 10 clear, 11 toggle.
- `iData`  in  `WIDTH*NUM_REQ`  per-requester operand (value for write, mask otherwise), requester k at bits [WIDTH*k +: WIDTH].
- `iLock`  in  `NUM_REQ`  per-requester lock request; used only when `CTRLREG_ARB_LOCK_EN` is defined.
- `iControlRegisterQ`  in  `WIDTH`  current register value, from `oControlRegister`.
- `oControlRegisterD`  out  `WIDTH`  next register value, to `iControlRegister`.
- `oAck`  out  `NUM_REQ`  one-cycle acknowledge, one-hot.
- `oGrantId`  out  `$clog2(NUM_REQ)`  index of the current or last winner.
- `oBusy`  out  1  high while not in IDLE.

## Operation
- FSM states: IDLE, APPLY, ACK, plus LOCKED when the macro is defined.
- IDLE:
  - If any `iReq` bit is set, select the winner by round-robin, searching upward from `last+1` and wrapping.
  - Latch the winner's id, op and data into internal registers, then go to APPLY.
  - If no `iReq` bit is set, stay in IDLE.
- APPLY:
  - `oControlRegisterD` = result, where Q is `iControlRegisterQ` and D is the latched operand:
    - write: D
    - set: Q | D
    - clear: Q & ~D
    - toggle: Q ^ D
  - Go to ACK.
- ACK:
  - `oAck[id]` = 1 and `last` = id.
  - Go to IDLE, or to LOCKED under the lock rule in Configuration.
- In every state except APPLY, `oControlRegisterD` = `iControlRegisterQ` (hold).
- Operand latching: the op and data are captured at grant. Changes to `iOp`/`iData` after grant have no effect on the operation in progress.
- Requester rule: deassert `iReq` in the cycle after `oAck`. A request still high when the FSM is back in IDLE counts as a new request.
- Dropping `iReq` after grant does not cancel the operation; it completes and is acknowledged.
- Round-robin: after reset `last` = `NUM_REQ-1`, so requester 0 has priority first.
- Reset values: state IDLE, `oAck` 0, `oBusy` 0, `oGrantId` 0, `last` `NUM_REQ-1`. `oControlRegisterD` = `iControlRegisterQ`, which is 0 in the cycle after reset because the register also resets.
- Reset mid-operation: the FSM aborts to IDLE, no ack is issued, and no write occurs.

## Timing
- Cycle 0 (IDLE): `iReq` sampled, winner latched.
- Cycle 1 (APPLY): `oControlRegisterD` carries the result; the register captures it at the end of the cycle.
- Cycle 2 (ACK): `oAck` high, and `oControlRegister` already shows the new value.
- Latency from request to ack: 2 cycles. Throughput: 1 operation per 3 cycles.
- `oBusy` is high in cycles 1–2.
- `oControlRegisterD` is combinational from `iControlRegisterQ` and the FSM state. There is no combinational path from `iReq`/`iOp`/`iData` to any output.

## Configuration
- `CTRLREG_ARB_LOCK_EN` defined:
  - If `iLock[id]` is high during ACK, the FSM goes to LOCKED instead of IDLE.
  - In LOCKED, only `iReq[id]` is considered; it is granted and proceeds APPLY → ACK → LOCKED.
  - LOCKED returns to IDLE when `iLock[id]` is low while in LOCKED or at ACK.
  - Other requesters wait.
- Macro undefined: `iLock` is ignored, the LOCKED state does not exist, and ACK always returns to IDLE.

## Structure
- Shared package `ctrlreg_pkg`:
  - Opcode constants `CTRL_OP_WRITE`/`SET`/`CLEAR`/`TOGGLE` (2'b00..2'b11).
  - FSM state encodings.
  - Default `WIDTH` 16.
- Sub-module `rr_priority_picker`: combinational round-robin selector taking request vector and `last` and producing a one-hot grant and its index. It is reusable by other arbiters in the design.

## Test plan
- Reset, then requester 1 writes 16'hA5A5 → `oAck[1]` two cycles after the request is sampled; register = A5A5; `oBusy` high for 2 cycles.
- Register = 16'h00F0; requester 0 sets 16'h0F00, then requester 2 clears 16'h00F0, then requester 3 toggles 16'hFFFF → register 0FF0, then 0F00, then F0FF.
- All four requesters high continuously → grants in order 0, 1, 2, 3, 0; each ack 3 cycles apart.
- Requester 2 changes `iData` from 16'h0001 to 16'hFFFF during APPLY → the register gets the latched 0001 result.
- Reset asserted during APPLY → no ack; register 0; next grant goes to requester 0.
- With `CTRLREG_ARB_LOCK_EN`: requester 1 is locked and requesters 0 and 1 both request repeatedly → only requester 1 is served until `iLock[1]` drops, then requester 0 is served next.
